jtdsp16_loop_cache: RTL and testbench

// - Parametrised instruction loop cache for the DSP16 core: captures NI consecutive ROM words on the first pass of a
//   "do K" loop, then replays them from local storage for the remaining K-1 passes with ROM fetches suppressed.
// - Sits between the ROM/XAAU fetch path and the controller; drives cache_dout/cache_hit into the X-bus mux.
// - Successor to the fixed 15-word cache: depth, data width, PC width and iteration-count width are parameters; adds redo and abort.

---
 rtl/jtdsp16_loop_cache.sv | 152 +++++++++++++++
 tb/tb_jtdsp16_loop_cache.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtdsp16_loop_cache.sv
// Instruction loop cache for the DSP16 "do K" / "redo K" loops: first pass fills from ROM, later passes replay locally.
// Optional feature: define JTDSP16_REDO_EN to accept "redo K"; otherwise redo/redo_k are ignored.
module jtdsp16_loop_cache #(
   parameter int DW    = 16,
   parameter int AW    = 12,
   parameter int DEPTH = 15,
   parameter int NIW   = 4,
   parameter int KW    = 7
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cen,
   input  logic          do_start,
   input  logic [NIW-1:0] do_ni,
   input  logic [KW-1:0] do_k,
   input  logic          redo,
   input  logic [KW-1:0] redo_k,
   input  logic [AW-1:0] pc_in,
   input  logic          adv,
   input  logic [DW-1:0] rom_dout,
   input  logic          abort,
   output logic [DW-1:0] cache_dout,
   output logic          cache_hit,
   output logic          busy,
   output logic          done,
   output logic [AW-1:0] resume_pc,
   output logic          err
);

`ifdef JTDSP16_REDO_EN
   localparam bit REDO_ON = 1'b1;
`else
   localparam bit REDO_ON = 1'b0;
`endif

   localparam int             AIW     = $clog2(DEPTH);
   localparam logic [NIW-1:0] DEPTH_N = NIW'(DEPTH);

   typedef enum logic [1:0] {IDLE, FILL, REPLAY} state_t;

   state_t         state;
   logic [NIW-1:0] ni;
   logic [NIW-1:0] wr_ptr;
   logic [NIW-1:0] rd_ptr;
   logic [KW-1:0]  count;
   logic           cache_valid;
   logic [DW-1:0]  mem [DEPTH];

   logic redo_cmd;
   logic last_word_w;
   logic last_word_r;
   logic last_pass;

   // Handshake: adv is the consume strobe from the controller. A word offered
   // (rom_dout in FILL, cache_dout in REPLAY) counts as taken only on a cycle
   // with cen=1 and adv=1; with adv=0 the offer simply stays in place.
   assign redo_cmd    = REDO_ON && redo;
   assign last_word_w = (wr_ptr == ni - 1'b1);
   assign last_word_r = (rd_ptr == ni - 1'b1);
   assign last_pass   = (count == KW'(1));

   assign busy       = (state != IDLE);
   assign cache_hit  = (state == REPLAY);
   assign cache_dout = cache_hit ? mem[rd_ptr[AIW-1:0]] : '0;

   always_ff @(posedge clk) begin
      if (cen && !abort && state == FILL && adv)
         mem[wr_ptr[AIW-1:0]] <= rom_dout;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         ni          <= '0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
         cache_valid <= 1'b0;
         resume_pc   <= '0;
         done        <= 1'b0;
         err         <= 1'b0;
      end else if (cen) begin
         done <= 1'b0;
         err  <= 1'b0;
         if (abort) begin
            state       <= IDLE;
            cache_valid <= 1'b0;
            count       <= '0;
         end else begin
            // Commands arriving mid-loop are refused but the loop keeps consuming words.
            if ((do_start || redo_cmd) && state != IDLE)
               err <= 1'b1;
            case (state)
               IDLE: begin
                  if (do_start) begin
                     if (do_ni == '0 || do_ni > DEPTH_N || do_k == '0) begin
                        err <= 1'b1;
                     end else begin
                        ni          <= do_ni;
                        count       <= do_k;
                        wr_ptr      <= '0;
                        cache_valid <= 1'b0;
                        resume_pc   <= pc_in + AW'(do_ni);
                        state       <= FILL;
                     end
                  end else if (redo_cmd) begin
                     if (!cache_valid || redo_k == '0) begin
                        err <= 1'b1;
                     end else begin
                        count  <= redo_k;
                        rd_ptr <= '0;
                        state  <= REPLAY;
                     end
                  end
               end
               FILL: begin
                  if (adv) begin
                     wr_ptr <= wr_ptr + 1'b1;
                     if (last_word_w) begin
                        count       <= count - 1'b1;
                        cache_valid <= REDO_ON;
                        rd_ptr      <= '0;
                        if (last_pass) begin
                           done  <= 1'b1;
                           state <= IDLE;
                        end else begin
                           state <= REPLAY;
                        end
                     end
                  end
               end
               REPLAY: begin
                  if (adv) begin
                     if (last_word_r) begin
                        rd_ptr <= '0;
                        count  <= count - 1'b1;
                        if (last_pass) begin
                           done  <= 1'b1;
                           state <= IDLE;
                        end
                     end else begin
                        rd_ptr <= rd_ptr + 1'b1;
                     end
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_jtdsp16_loop_cache.sv
// Bench for jtdsp16_loop_cache: word-count reference model checked every cycle, plus literal directed checks.
// Honours JTDSP16_REDO_EN the same way as the design.
module tb_jtdsp16_loop_cache;

`ifdef JTDSP16_REDO_EN
   localparam bit REDO_EN = 1'b1;
`else
   localparam bit REDO_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst, cen, do_start, redo, adv, abort;
   logic [4:0]  do_ni;
   logic [6:0]  do_k, redo_k;
   logic [11:0] pc_in;
   logic [15:0] rom_dout;
   logic [15:0] cache_dout;
   logic        cache_hit, busy, done, err;
   logic [11:0] resume_pc;

   int tests = 0;
   int fails = 0;
   bit chk_en = 1'b0;

   jtdsp16_loop_cache #(.DW(16), .AW(12), .DEPTH(15), .NIW(5), .KW(7)) dut (
      .clk(clk), .rst(rst), .cen(cen), .do_start(do_start), .do_ni(do_ni), .do_k(do_k),
      .redo(redo), .redo_k(redo_k), .pc_in(pc_in), .adv(adv), .rom_dout(rom_dout),
      .abort(abort), .cache_dout(cache_dout), .cache_hit(cache_hit), .busy(busy),
      .done(done), .resume_pc(resume_pc), .err(err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
      #1;
   endtask

   // Reference model: a loop is a stream of ni*K consumed words; the first
   // m_fill of them come from ROM, word n of the stream is body[n mod ni].
   bit          m_act, m_valid, m_done, m_err;
   int          m_n, m_total, m_fill, m_ni;
   logic [11:0] m_rpc;
   logic [15:0] m_body [16];

   task automatic model_step();
      bit cmd = do_start || (REDO_EN && redo);
      m_done = 1'b0;
      m_err  = 1'b0;
      if (abort) begin
         m_act   = 1'b0;
         m_valid = 1'b0;
         return;
      end
      if (cmd && m_act) m_err = 1'b1;
      if (!m_act) begin
         if (do_start) begin
            if (do_ni == 0 || do_ni > 15 || do_k == 0) begin
               m_err = 1'b1;
            end else begin
               m_act   = 1'b1;
               m_ni    = int'(do_ni);
               m_fill  = m_ni;
               m_n     = 0;
               m_total = m_ni * int'(do_k);
               m_valid = 1'b0;
               m_rpc   = pc_in + 12'(do_ni);
            end
         end else if (REDO_EN && redo) begin
            if (!m_valid || redo_k == 0) begin
               m_err = 1'b1;
            end else begin
               m_act   = 1'b1;
               m_fill  = 0;
               m_n     = 0;
               m_total = m_ni * int'(redo_k);
            end
         end
      end else if (adv) begin
         if (m_n < m_fill) m_body[m_n] = rom_dout;
         m_n++;
         if (m_n == m_fill) m_valid = REDO_EN;
         if (m_n == m_total) begin
            m_done = 1'b1;
            m_act  = 1'b0;
         end
      end
   endtask

   always @(posedge clk) begin
      if (!rst) begin
         m_act = 1'b0; m_valid = 1'b0; m_done = 1'b0; m_err = 1'b0;
         m_n = 0; m_total = 0; m_fill = 0; m_ni = 1; m_rpc = '0;
      end else if (cen) begin
         model_step();
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("busy", 32'(busy), 32'(m_act));
         chk("cache_hit", 32'(cache_hit), 32'(m_act && m_n >= m_fill));
         if (m_act && m_n >= m_fill)
            chk("cache_dout", 32'(cache_dout), 32'(m_body[m_n % m_ni]));
         chk("done", 32'(done), 32'(m_done));
         chk("err", 32'(err), 32'(m_err));
         chk("resume_pc", 32'(resume_pc), 32'(m_rpc));
      end
   end

   task automatic start_loop(input int ni, input int k, input int pc);
      do_start = 1'b1;
      do_ni    = 5'(ni);
      do_k     = 7'(k);
      pc_in    = 12'(pc);
      tick();
      do_start = 1'b0;
   endtask

   int ni_t [3] = '{0, 16, 4};
   int k_t  [3] = '{5, 5, 0};
   int hits, cyc, r;

   initial begin
      rst = 1'b0; cen = 1'b1; do_start = 1'b0; redo = 1'b0; adv = 1'b0; abort = 1'b0;
      do_ni = '0; do_k = '0; redo_k = '0; pc_in = '0; rom_dout = '0;
      repeat (3) @(posedge clk);
      @(negedge clk); #1;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_hit", 32'(cache_hit), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_resume_pc", 32'(resume_pc), 32'd0);
      chk("rst_dout", 32'(cache_dout), 32'd0);
      rst = 1'b1;
      chk_en = 1'b1;
      tick();

      // NI=3 K=2 at 0x100: fill A,B,C then replay A,B,C.
      start_loop(3, 2, 'h100);
      chk("d1_busy", 32'(busy), 32'd1);
      chk("d1_fill_hit", 32'(cache_hit), 32'd0);
      adv = 1'b1; rom_dout = 16'h000A; tick();
      chk("d1_fill_hit2", 32'(cache_hit), 32'd0);
      rom_dout = 16'h000B; tick();
      rom_dout = 16'h000C; tick();
      rom_dout = 16'hDEAD;
      chk("d1_rep_a", 32'({cache_hit, cache_dout}), 32'h1000A); tick();
      chk("d1_rep_b", 32'({cache_hit, cache_dout}), 32'h1000B); tick();
      chk("d1_rep_c", 32'({cache_hit, cache_dout}), 32'h1000C); tick();
      adv = 1'b0;
      chk("d1_done", 32'({done, busy, cache_hit}), 32'b100);
      chk("d1_resume_pc", 32'(resume_pc), 32'h103);
      tick();

      // Rejected commands.
      for (int i = 0; i < 3; i++) begin
         start_loop(ni_t[i], k_t[i], 'h300);
         chk("bad_cmd_err", 32'({err, busy}), 32'b10);
         tick();
      end

      // NI=2 {X,Y} then redo K=3.
      start_loop(2, 1, 'h200);
      adv = 1'b1; rom_dout = 16'h1111; tick();
      rom_dout = 16'h2222; tick();
      adv = 1'b0;
      chk("d2_done", 32'(done), 32'd1);
      redo = 1'b1; redo_k = 7'd3; tick();
      redo = 1'b0;
`ifdef JTDSP16_REDO_EN
      adv = 1'b1;
      for (int i = 0; i < 6; i++) begin
         chk("redo_word", 32'({cache_hit, cache_dout}), (i % 2 == 0) ? 32'h11111 : 32'h12222);
         tick();
      end
      adv = 1'b0;
      chk("redo_done", 32'({done, busy}), 32'b10);
`else
      chk("redo_ignored", 32'({busy, err}), 32'b00);
`endif
      tick();

      // Abort during pass 2 of 4, then redo must be refused.
      start_loop(3, 4, 'h040);
      adv = 1'b1;
      repeat (4) begin rom_dout = 16'($urandom); tick(); end
      abort = 1'b1; tick();
      abort = 1'b0; adv = 1'b0;
      chk("abort_idle", 32'({busy, cache_hit, done}), 32'b000);
      redo = 1'b1; redo_k = 7'd2; tick();
      redo = 1'b0;
`ifdef JTDSP16_REDO_EN
      chk("abort_redo_err", 32'({err, busy}), 32'b10);
`else
      chk("abort_redo_ignored", 32'({err, busy}), 32'b00);
`endif
      tick();

      // Longest loop: NI=15, K=127.
      start_loop(15, 127, 'hFF8);
      adv = 1'b1; hits = 0; cyc = 0;
      while (busy && cyc < 4000) begin
         if (cache_hit) hits++;
         rom_dout = 16'($urandom);
         tick();
         cyc++;
      end
      adv = 1'b0;
      chk("big_bound", 32'(cyc < 4000), 32'd1);
      chk("big_cycles", 32'(cyc), 32'd1905);
      chk("big_hits", 32'(hits), 32'd1890);
      chk("big_done", 32'(done), 32'd1);
      chk("big_resume_pc", 32'(resume_pc), 32'h007);
      tick();

      // NI=4 K=2 with adv toggling and cen at 50%.
      start_loop(4, 2, 'h500);
      cyc = 0;
      while (m_act && cyc < 200) begin
         adv = ~adv;
         cen = 1'($urandom_range(0, 1));
         rom_dout = 16'($urandom);
         tick();
         cyc++;
      end
      chk("toggle_bound", 32'(cyc < 200), 32'd1);
      cen = 1'b1; adv = 1'b0;
      tick();

      // Random traffic.
      repeat (6000) begin
         do_start = 1'b0; redo = 1'b0; abort = 1'b0;
         r = $urandom_range(0, 99);
         if (!m_act) begin
            do_start = (r < 25);
            redo     = (r >= 15 && r < 35);
            abort    = (r == 99);
         end else begin
            abort    = (r < 2);
            do_start = (r >= 2 && r < 4);
            redo     = (r >= 4 && r < 6);
         end
         do_ni    = 5'($urandom_range(0, 16));
         do_k     = 7'($urandom_range(0, 6));
         redo_k   = 7'($urandom_range(0, 5));
         pc_in    = 12'($urandom);
         rom_dout = 16'($urandom);
         adv      = ($urandom_range(0, 99) < 70);
         cen      = ($urandom_range(0, 99) < 70);
         tick();
      end

      chk_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
